// File: rtl/paint_grid_tracker.sv
// paint_grid_tracker
//   Cursor-driven paint grid of HSIZE x VSIZE one-bit cells, displayed as
//   CELL x CELL pixel blocks. Button releases move a saturating cursor; mode
//   selects paint / erase at the cursor; a clear pulse (and reset) starts a
//   one-cell-per-cycle wipe sweep.
//
// Ports
//   CLK         rising-edge clock
//   RESET       synchronous, active-low reset
//   PushButton  active-low buttons: [0] right, [1] up, [2] down, [3] left
//   mode        00/11 move-only, 01 paint, 10 erase
//   clear       one-cycle grid wipe request (honoured in IDLE only)
//   hcnt, vcnt  display pixel coordinates
//   on          painted state of the cell under (hcnt,vcnt), latency 1
//   cursor_on   (hcnt,vcnt) lies inside the cursor cell, latency 1
//   busy        clear sweep in progress
//   pixel_cnt   painted cells x CELL x CELL
//   col_addr    cursor column
//   row_addr    cursor row
module paint_grid_tracker #(
  parameter int unsigned HSIZE = 96,
  parameter int unsigned VSIZE = 54,
  parameter int unsigned CELL  = 5,
  parameter int unsigned CNT_W = 24
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [3:0]                PushButton,
  input  logic [1:0]                mode,
  input  logic                      clear,
  input  logic [13:0]               hcnt,
  input  logic [13:0]               vcnt,
  output logic                      on,
  output logic                      cursor_on,
  output logic                      busy,
  output logic [CNT_W-1:0]          pixel_cnt,
  output logic [$clog2(HSIZE)-1:0]  col_addr,
  output logic [$clog2(VSIZE)-1:0]  row_addr
);

  localparam int unsigned N    = HSIZE * VSIZE;
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int unsigned CAW  = $clog2(HSIZE);
  localparam int unsigned RAW  = $clog2(VSIZE);
  localparam int unsigned AREA = CELL * CELL;
  localparam int unsigned PW   = CNT_W + CW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]     state;
  logic [AW-1:0]  sweep;
  logic [3:0]     btn_q;
  logic [CW-1:0]  cnt;
  logic           grid [N];

  logic [3:0]     ev;
  logic [CAW-1:0] col_n;
  logic [RAW-1:0] row_n;
  logic [AW-1:0]  cur_idx;
  logic           cur_cell;
  logic           we;
  logic [AW-1:0]  waddr;
  logic           wdata;
  logic           in_range;
  int unsigned    hcol;
  int unsigned    vrow;
  logic [AW-1:0]  disp_idx;
  logic           on_n;
  logic           cursor_n;
  logic [PW-1:0]  prod;

  assign busy = (state == ST_CLEAR);

  // Release event: input high now, registered copy low.
  assign ev = PushButton & ~btn_q;

  assign cur_idx  = AW'(32'(row_addr) * HSIZE + 32'(col_addr));
  assign cur_cell = grid[cur_idx];

  // Only the highest-priority event (right > left > up > down) is applied.
  always_comb begin
    col_n = col_addr;
    row_n = row_addr;
    if (ev[0]) begin
      if (col_addr != CAW'(HSIZE - 1)) col_n = col_addr + CAW'(1);
    end else if (ev[3]) begin
      if (col_addr != '0) col_n = col_addr - CAW'(1);
    end else if (ev[1]) begin
      if (row_addr != RAW'(VSIZE - 1)) row_n = row_addr + RAW'(1);
    end else if (ev[2]) begin
      if (row_addr != '0) row_n = row_addr - RAW'(1);
    end
  end

  // Single grid write port: sweep in CLEAR, paint/erase at the pre-move
  // cursor in IDLE; a clear request suppresses paint/erase.
  always_comb begin
    we    = 1'b0;
    waddr = cur_idx;
    wdata = 1'b0;
    if (state == ST_CLEAR) begin
      we    = 1'b1;
      waddr = sweep;
    end else if (!clear && mode == 2'b01) begin
      we    = 1'b1;
      wdata = 1'b1;
    end else if (!clear && mode == 2'b10) begin
      we    = 1'b1;
    end
    if (!RESET) we = 1'b0;
  end

  // Grid contents are not reset; the sweep zeroes them before IDLE.
  always_ff @(posedge CLK) begin
    if (we) grid[waddr] <= wdata;
  end

  // Display lookup.
  always_comb begin
    hcol     = 32'(hcnt) / CELL;
    vrow     = 32'(vcnt) / CELL;
    in_range = (32'(hcnt) < HSIZE * CELL) && (32'(vcnt) < VSIZE * CELL);
    disp_idx = '0;
    on_n     = 1'b0;
    cursor_n = 1'b0;
    if (in_range) begin
      disp_idx = AW'(vrow * HSIZE + hcol);
      on_n     = (state == ST_IDLE) && grid[disp_idx];
      cursor_n = (hcol == 32'(col_addr)) && (vrow == 32'(row_addr));
    end
  end

  assign prod = PW'(cnt) * PW'(AREA);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_CLEAR;
      sweep     <= '0;
      btn_q     <= '1;
      col_addr  <= '0;
      row_addr  <= '0;
      cnt       <= '0;
      pixel_cnt <= '0;
      on        <= 1'b0;
      cursor_on <= 1'b0;
    end else begin
      btn_q     <= PushButton;
      pixel_cnt <= prod[CNT_W-1:0];
      on        <= on_n;
      cursor_on <= cursor_n;
      if (state == ST_CLEAR) begin
        cnt <= '0;
        if (sweep == AW'(N - 1)) begin
          state <= ST_IDLE;
          sweep <= '0;
        end else begin
          sweep <= sweep + AW'(1);
        end
      end else if (clear) begin
        state <= ST_CLEAR;
        sweep <= '0;
        cnt   <= '0;
      end else begin
        col_addr <= col_n;
        row_addr <= row_n;
        if (mode == 2'b01 && !cur_cell)
          cnt <= cnt + CW'(1);
        else if (mode == 2'b10 && cur_cell)
          cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/paint_grid_tracker.md
PAINT_GRID_TRACKER -- requirements
Module: paint_grid_tracker

Interface
REQ-001 Parameter HSIZE, 96, grid columns (>=2).
REQ-002 Parameter VSIZE, 54, grid rows (>=2).
REQ-003 Parameter CELL, 5, cell edge in display pixels (>=1).
REQ-004 Parameter CNT_W, 24, width of pixel_cnt.
REQ-005 CLK  in  1  single clock; all logic rising-edge.
REQ-006 RESET  in  1  synchronous, active-low reset.
REQ-007 PushButton  in  4  active-low buttons: [0] right, [1] up, [2] down, [3] left.
REQ-008 mode  in  2  00 move-only, 01 paint, 10 erase, 11 move-only.
REQ-009 clear  in  1  one-cycle pulse requesting a grid wipe.
REQ-010 hcnt  in  14  display pixel x.
REQ-011 vcnt  in  14  display pixel y.
REQ-012 on  out  1  painted state of the cell under (hcnt,vcnt).
REQ-013 cursor_on  out  1  (hcnt,vcnt) lies inside the cursor cell.
REQ-014 busy  out  1  clear sweep in progress.
REQ-015 pixel_cnt  out  CNT_W  painted cells x CELL x CELL.
REQ-016 col_addr / row_addr  out  clog2(HSIZE) / clog2(VSIZE)  cursor position.

Function
REQ-017 Grid storage: HSIZE*VSIZE one-bit cells, at most one cell write per cycle.
REQ-018 Button event: registered copy of PushButton; event on 0->1 (release) transition of a bit.
REQ-019 Multiple events same cycle: only highest-priority applied, order right > left > up > down; others discarded.
REQ-020 Cursor moves saturate: right stops at HSIZE-1, left at 0, up at VSIZE-1, down at 0; no wrap.
REQ-021 FSM states CLEAR and IDLE; reset enters CLEAR with sweep address 0.
REQ-022 CLEAR: writes 0 to one cell per cycle, linear address 0..HSIZE*VSIZE-1; after last address -> IDLE next cycle; busy=1 throughout CLEAR.
REQ-023 CLEAR occupies exactly HSIZE*VSIZE cycles; button events, mode writes and clear pulses ignored during it.
REQ-024 IDLE + clear=1 -> CLEAR next cycle, takes priority over paint/erase that cycle; cursor position retained.
REQ-025 IDLE, mode 01: cell at current cursor written 1 every cycle; if it was 0, painted counter +1.
REQ-026 IDLE, mode 10: cell at cursor written 0 every cycle; if it was 1, painted counter -1.
REQ-027 Cursor move and paint/erase same cycle: write uses pre-move cursor.
REQ-028 Painted counter: clog2(HSIZE*VSIZE+1) bits, never under/overflows by construction; zeroed on entry to CLEAR.
REQ-029 pixel_cnt = counter * CELL*CELL, registered, updated one cycle after counter change, truncated to CNT_W.
REQ-030 Display lookup: col = hcnt/CELL, row = vcnt/CELL; row 0 at vcnt 0, col 0 at hcnt 0.
REQ-031 on and cursor_on registered: reflect hcnt/vcnt and grid state of the previous cycle (latency 1).
REQ-032 (hcnt,vcnt) outside HSIZE*CELL x VSIZE*CELL: on=0, cursor_on=0.
REQ-033 During CLEAR: on=0 for all pixels; cursor_on still valid.

Reset
REQ-034 RESET=0 at a rising edge: cursor (0,0), button register 4'b1111, counter 0, pixel_cnt 0, on 0, cursor_on 0, FSM CLEAR at address 0, busy 1 next cycle.
REQ-035 RESET asserted mid-CLEAR or mid-paint: sweep restarts at address 0; no partial state preserved.
REQ-036 Grid contents not required to reset directly; guaranteed zero by CLEAR completing before IDLE.

Verification
REQ-037 HSIZE=4,VSIZE=3: release RESET -> busy=1 for exactly 12 cycles, then 0; pixel_cnt=0.
REQ-038 CELL=5, mode 01 at (0,0), two right releases, mode 00 -> cells (0,0),(1,0),(2,0) painted; pixel_cnt=75; on=1 for hcnt 0..14,vcnt 0..4 one cycle after.
REQ-039 Cursor (HSIZE-1,0), five right releases -> col_addr stays HSIZE-1; right+up release same cycle -> column change only.
REQ-040 Paint 3 cells then mode 10 over one of them -> pixel_cnt 75 -> 50; erase an unpainted cell -> stays 50.
REQ-041 clear pulse with mode 01 held -> busy for HSIZE*VSIZE cycles, buttons ignored, pixel_cnt 0, then painting at retained cursor resumes (pixel_cnt 25).
REQ-042 RESET pulsed midway through a clear sweep -> busy restarts full HSIZE*VSIZE count; cursor (0,0).
